// File: rtl/xrv1_div_iq_pkg.sv
// Shared types for the divider issue queue: opcode encoding and the packed queue entry.
package xrv1_div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_ITAG_W = 4;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_opc_e;

  // Field widths are fixed here; the top-level width parameters must match them.
  typedef struct packed {
    div_opc_e                opc;
    logic [DIV_DATA_W-1:0]   src0;
    logic [DIV_DATA_W-1:0]   src1;
    logic [DIV_ITAG_W-1:0]   itag;
  } div_iq_entry_t;

endpackage

// File: rtl/xrv1_div_iq_fifo.sv
// In-order entry store with pointers, occupancy count and flush; head visible one cycle after write.
// Caller must not push when full; flush suppresses push and pop in the same cycle.
module xrv1_div_iq_fifo
  import xrv1_div_pkg::*;
#(
  parameter int depth_p = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_vld,
  input  div_iq_entry_t             push_dat,
  input  logic                      pop_vld,
  input  logic                      flush,
  output div_iq_entry_t             head_dat,
  output logic [$clog2(depth_p):0]  cnt,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = $clog2(depth_p);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(depth_p);

  div_iq_entry_t    mem [depth_p];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign push = push_vld && !flush;
  assign pop  = pop_vld && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);

endmodule

// File: rtl/xrv1_div_iq.sv
// Issue queue feeding the divider one op at a time; enqueue-to-request latency is one cycle.
// Dispatch is stalled only when full; the divider stalls via div_rdy_i and no new op issues while one is in flight.
module xrv1_div_iq
  import xrv1_div_pkg::*;
#(
  parameter int data_width_p = DIV_DATA_W,
  parameter int ITAG_WIDTH_P = DIV_ITAG_W,
  parameter int depth_p      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      iq_vld_i,
  output logic                      iq_rdy_o,
  input  logic [1:0]                iq_opc_i,
  input  logic [data_width_p-1:0]   iq_src0_i,
  input  logic [data_width_p-1:0]   iq_src1_i,
  input  logic [ITAG_WIDTH_P-1:0]   iq_itag_i,
  output logic                      div_req_o,
  input  logic                      div_rdy_i,
  output logic [1:0]                div_opc_o,
  output logic [data_width_p-1:0]   div_src0_o,
  output logic [data_width_p-1:0]   div_src1_o,
  output logic [ITAG_WIDTH_P-1:0]   div_itag_o,
  input  logic                      div_res_vld_i,
  input  logic                      flush_i,
  output logic [$clog2(depth_p):0]  iq_cnt_o,
  output logic                      iq_busy_o
);

  div_iq_entry_t in_ent;
  div_iq_entry_t head_ent;
  logic          fifo_full;
  logic          fifo_empty;
  logic          enq;
  logic          xfer;
  logic          busy;
  logic          stale;

  assign in_ent = '{opc: div_opc_e'(iq_opc_i), src0: iq_src0_i, src1: iq_src1_i, itag: iq_itag_i};

  assign iq_rdy_o  = !fifo_full;
  assign enq       = iq_vld_i && iq_rdy_o && !flush_i;
  assign div_req_o = !fifo_empty && !busy && !flush_i;
  assign xfer      = div_req_o && div_rdy_i;

  xrv1_div_iq_fifo #(
    .depth_p (depth_p)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push_vld (enq),
    .push_dat (in_ent),
    .pop_vld  (xfer),
    .flush    (flush_i),
    .head_dat (head_ent),
    .cnt      (iq_cnt_o),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Zero the data bus whenever no request is presented.
  assign div_opc_o  = div_req_o ? head_ent.opc  : 2'b00;
  assign div_src0_o = div_req_o ? head_ent.src0 : '0;
  assign div_src1_o = div_req_o ? head_ent.src1 : '0;
  assign div_itag_o = div_req_o ? head_ent.itag : '0;

  // Transfer and completion never coincide because req is gated by busy.
  always_ff @(posedge clk_i) begin
    if (rst_i)              busy <= 1'b0;
    else if (xfer)          busy <= 1'b1;
    else if (div_res_vld_i) busy <= 1'b0;
  end

  assign iq_busy_o = busy;

  // A completion for an op orphaned by reset is expected; any other idle completion is a protocol error.
  always_ff @(posedge clk_i) begin
    if (rst_i)     stale <= 1'b1;
    else if (xfer) stale <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(div_res_vld_i && !busy && !stale))
        else $error("div_res_vld_i asserted with no op in flight");
    end
  end

endmodule

// File: tb/tb_xrv1_div_iq.sv
// Bench for xrv1_div_iq: directed scenarios followed by randomized traffic against a queue-based model.
module tb_xrv1_div_iq;

  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_i, iq_vld_i, div_rdy_i, div_res_vld_i, flush_i;
  logic [1:0]    iq_opc_i;
  logic [DW-1:0] iq_src0_i, iq_src1_i;
  logic [TW-1:0] iq_itag_i;
  logic          iq_rdy_o, div_req_o, iq_busy_o;
  logic [1:0]    div_opc_o;
  logic [DW-1:0] div_src0_o, div_src1_o;
  logic [TW-1:0] div_itag_o;
  logic [2:0]    iq_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]    opc;
    logic [DW-1:0] s0;
    logic [DW-1:0] s1;
    logic [TW-1:0] itag;
  } op_t;

  op_t mq[$];
  bit  mbusy;

  always #5 clk = ~clk;

  xrv1_div_iq #(
    .data_width_p (DW),
    .ITAG_WIDTH_P (TW),
    .depth_p      (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .iq_vld_i      (iq_vld_i),
    .iq_rdy_o      (iq_rdy_o),
    .iq_opc_i      (iq_opc_i),
    .iq_src0_i     (iq_src0_i),
    .iq_src1_i     (iq_src1_i),
    .iq_itag_i     (iq_itag_i),
    .div_req_o     (div_req_o),
    .div_rdy_i     (div_rdy_i),
    .div_opc_o     (div_opc_o),
    .div_src0_o    (div_src0_o),
    .div_src1_o    (div_src1_o),
    .div_itag_o    (div_itag_o),
    .div_res_vld_i (div_res_vld_i),
    .flush_i       (flush_i),
    .iq_cnt_o      (iq_cnt_o),
    .iq_busy_o     (iq_busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Drive one cycle of inputs, then compare every output against the model's current state.
  task automatic pre(input bit vld, input logic [1:0] opc, input logic [DW-1:0] s0,
                     input logic [DW-1:0] s1, input logic [TW-1:0] itag, input bit drdy,
                     input bit res, input bit fl, input bit rs, input string tag);
    bit            req_e;
    logic [1:0]    e_opc;
    logic [DW-1:0] e_s0, e_s1;
    logic [TW-1:0] e_itag;
    iq_vld_i      = vld;
    iq_opc_i      = opc;
    iq_src0_i     = s0;
    iq_src1_i     = s1;
    iq_itag_i     = itag;
    div_rdy_i     = drdy;
    div_res_vld_i = res;
    flush_i       = fl;
    rst_i         = rs;
    #1;
    req_e  = (mq.size() != 0) && !mbusy && !fl;
    e_opc  = '0;
    e_s0   = '0;
    e_s1   = '0;
    e_itag = '0;
    if (req_e) begin
      e_opc  = mq[0].opc;
      e_s0   = mq[0].s0;
      e_s1   = mq[0].s1;
      e_itag = mq[0].itag;
    end
    chk({tag, "_rdy"},  iq_rdy_o,   64'(mq.size() < DEPTH));
    chk({tag, "_cnt"},  iq_cnt_o,   64'(mq.size()));
    chk({tag, "_busy"}, iq_busy_o,  64'(mbusy));
    chk({tag, "_req"},  div_req_o,  64'(req_e));
    chk({tag, "_opc"},  div_opc_o,  64'(e_opc));
    chk({tag, "_src0"}, div_src0_o, 64'(e_s0));
    chk({tag, "_src1"}, div_src1_o, 64'(e_s1));
    chk({tag, "_itag"}, div_itag_o, 64'(e_itag));
  endtask

  // Clock edge: apply the queue rules to the model using the inputs held across the edge.
  task automatic post();
    bit  x, e;
    op_t o;
    @(posedge clk);
    x = (mq.size() != 0) && !mbusy && !flush_i && div_rdy_i;
    e = iq_vld_i && (mq.size() < DEPTH) && !flush_i;
    o = '{iq_opc_i, iq_src0_i, iq_src1_i, iq_itag_i};
    if (rst_i) begin
      mq.delete();
      mbusy = 1'b0;
    end else if (flush_i) begin
      mq.delete();
      if (div_res_vld_i) mbusy = 1'b0;
    end else begin
      if (div_res_vld_i) mbusy = 1'b0;
      if (x) begin
        void'(mq.pop_front());
        mbusy = 1'b1;
      end
      if (e) mq.push_back(o);
    end
    #1;
  endtask

  task automatic step(input bit vld, input logic [1:0] opc, input logic [DW-1:0] s0,
                      input logic [DW-1:0] s1, input logic [TW-1:0] itag, input bit drdy,
                      input bit res, input bit fl, input bit rs, input string tag);
    pre(vld, opc, s0, s1, itag, drdy, res, fl, rs, tag);
    post();
  endtask

  task automatic pre_idle(input bit drdy, input bit res, input bit fl, input bit rs, input string tag);
    pre(1'b0, 2'd0, '0, '0, '0, drdy, res, fl, rs, tag);
  endtask

  task automatic step_idle(input bit drdy, input bit res, input bit fl, input bit rs, input string tag);
    pre_idle(drdy, res, fl, rs, tag);
    post();
  endtask

  task automatic enq_op(input logic [TW-1:0] itag, input bit drdy, input string tag);
    step(1'b1, 2'($urandom_range(0, 3)), DW'($urandom), DW'($urandom), itag, drdy, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    rst_i = 1'b1; iq_vld_i = 1'b0; iq_opc_i = '0; iq_src0_i = '0; iq_src1_i = '0;
    iq_itag_i = '0; div_rdy_i = 1'b0; div_res_vld_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete();
    mbusy = 1'b0;

    // Reset state
    pre_idle(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    chk("reset_rdy",  iq_rdy_o,  64'd1);
    chk("reset_req",  div_req_o, 64'd0);
    chk("reset_cnt",  iq_cnt_o,  64'd0);
    chk("reset_busy", iq_busy_o, 64'd0);
    post();

    // Single DIV 100/7 itag 3
    step(1'b1, 2'b00, 32'd100, 32'd7, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, "enq1");
    pre_idle(1'b1, 1'b0, 1'b0, 1'b0, "iss1");
    chk("iss1_req_k",  div_req_o,  64'd1);
    chk("iss1_opc_k",  div_opc_o,  64'd0);
    chk("iss1_src0_k", div_src0_o, 64'd100);
    chk("iss1_src1_k", div_src1_o, 64'd7);
    chk("iss1_itag_k", div_itag_o, 64'd3);
    post();
    pre_idle(1'b0, 1'b0, 1'b0, 1'b0, "bsy1");
    chk("bsy1_busy_k", iq_busy_o, 64'd1);
    chk("bsy1_req_k",  div_req_o, 64'd0);
    post();
    step_idle(1'b0, 1'b1, 1'b0, 1'b0, "res1");
    pre_idle(1'b0, 1'b0, 1'b0, 1'b0, "done1");
    chk("done1_busy_k", iq_busy_o, 64'd0);
    post();

    // Fill to full, reject a fifth, then drain in order
    for (int i = 0; i < 4; i++) enq_op(TW'(i), 1'b0, "fill");
    pre(1'b1, 2'b01, 32'd9, 32'd9, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, "full");
    chk("full_cnt_k", iq_cnt_o, 64'd4);
    chk("full_rdy_k", iq_rdy_o, 64'd0);
    post();
    for (int k = 0; k < 4; k++) begin
      pre_idle(1'b1, 1'b0, 1'b0, 1'b0, "ord");
      chk("ord_req_k",  div_req_o,  64'd1);
      chk("ord_itag_k", div_itag_o, 64'(k));
      post();
      pre_idle(1'b1, 1'b0, 1'b0, 1'b0, "ordbsy");
      chk("ordbsy_req_k", div_req_o, 64'd0);
      post();
      step_idle(1'b1, 1'b1, 1'b0, 1'b0, "ordres");
    end

    // Transfer plus enqueue at count 3 keeps count at 3
    for (int i = 0; i < 3; i++) enq_op(TW'(i + 4), 1'b0, "fill3");
    pre(1'b1, 2'b10, 32'd55, 32'd5, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, "xe");
    chk("xe_cnt_k", iq_cnt_o,  64'd3);
    chk("xe_rdy_k", iq_rdy_o,  64'd1);
    chk("xe_req_k", div_req_o, 64'd1);
    post();
    pre_idle(1'b0, 1'b0, 1'b0, 1'b0, "xe2");
    chk("xe2_cnt_k",  iq_cnt_o,  64'd3);
    chk("xe2_busy_k", iq_busy_o, 64'd1);
    post();
    step_idle(1'b0, 1'b1, 1'b0, 1'b0, "xeres");

    // Flush with one in flight and two queued
    step_idle(1'b1, 1'b0, 1'b0, 1'b0, "fliss");
    pre_idle(1'b1, 1'b0, 1'b1, 1'b0, "fl");
    chk("fl_req_k", div_req_o, 64'd0);
    chk("fl_cnt_k", iq_cnt_o,  64'd2);
    post();
    pre_idle(1'b1, 1'b0, 1'b0, 1'b0, "fl1");
    chk("fl1_cnt_k",  iq_cnt_o,  64'd0);
    chk("fl1_busy_k", iq_busy_o, 64'd1);
    post();
    repeat (3) step_idle(1'b1, 1'b0, 1'b0, 1'b0, "flwait");
    step_idle(1'b1, 1'b1, 1'b0, 1'b0, "flres");
    pre_idle(1'b1, 1'b0, 1'b0, 1'b0, "fl2");
    chk("fl2_busy_k", iq_busy_o, 64'd0);
    chk("fl2_req_k",  div_req_o, 64'd0);
    post();

    // Reset mid-operation, then a late completion
    for (int i = 0; i < 4; i++) enq_op(TW'(i + 8), 1'b0, "fillr");
    step_idle(1'b1, 1'b0, 1'b0, 1'b0, "rsiss");
    pre_idle(1'b0, 1'b0, 1'b0, 1'b0, "prerst");
    chk("prerst_cnt_k",  iq_cnt_o,  64'd3);
    chk("prerst_busy_k", iq_busy_o, 64'd1);
    post();
    step_idle(1'b0, 1'b0, 1'b0, 1'b1, "rst");
    pre_idle(1'b0, 1'b0, 1'b0, 1'b0, "postrst");
    chk("postrst_cnt_k",  iq_cnt_o,  64'd0);
    chk("postrst_busy_k", iq_busy_o, 64'd0);
    chk("postrst_req_k",  div_req_o, 64'd0);
    chk("postrst_rdy_k",  iq_rdy_o,  64'd1);
    post();
    step_idle(1'b0, 1'b1, 1'b0, 1'b0, "late");
    pre_idle(1'b0, 1'b0, 1'b0, 1'b0, "postlate");
    chk("postlate_cnt_k",  iq_cnt_o,  64'd0);
    chk("postlate_busy_k", iq_busy_o, 64'd0);
    post();

    // Randomized traffic; completions only while the model has an op in flight
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), DW'($urandom), DW'($urandom),
           TW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           mbusy && ($urandom_range(0, 2) == 0), $urandom_range(0, 24) == 0,
           $urandom_range(0, 79) == 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
